// File: rtl/router_fsm_pkg.sv
// -----------------------------------------------------------------------------
// router_fsm_pkg
//   Shared definitions for the 1x3 router packet-control FSM.
//   - state_e           : 3-bit binary state codes DA/LFD/LD/FFS/LAF/LP/CPE/WTE
//   - ADDR_INVALID      : header address value that selects no output port
//   - ADDR_W_DEF        : default width of the header address field
//   - NUM_PORTS_DEF     : default number of output ports
// -----------------------------------------------------------------------------
package router_fsm_pkg;

  typedef enum logic [2:0] {
    DA  = 3'd0,  // DECODE_ADDRESS
    LFD = 3'd1,  // LOAD_FIRST_DATA
    LD  = 3'd2,  // LOAD_DATA
    FFS = 3'd3,  // FIFO_FULL_STATE
    LAF = 3'd4,  // LOAD_AFTER_FULL
    LP  = 3'd5,  // LOAD_PARITY
    CPE = 3'd6,  // CHECK_PARITY_ERROR
    WTE = 3'd7   // WAIT_TILL_EMPTY
  } state_e;

  localparam logic [1:0]  ADDR_INVALID  = 2'b11;
  localparam int          ADDR_W_DEF    = 2;
  localparam int          NUM_PORTS_DEF = 3;

endpackage

// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
//   Packet-control FSM for the 1x3 router. Drives the register stage load
//   controls, the FIFO write qualifier and source back-pressure.
//
// Ports
//   clk                  in  clock, rising edge
//   resetn               in  asynchronous active-low reset
//   packet_valid         in  source byte valid (falls with the parity byte)
//   datain[ADDR_W-1:0]   in  header address bits
//   fifo_full            in  full flag of the FIFO selected by the latched address
//   fifo_empty_0..2      in  empty flags of FIFOs 0..2
//   soft_reset_0..2      in  timeout soft resets of FIFOs 0..2
//   parity_done          in  register stage captured the parity byte
//   low_packet_valid     in  register stage saw packet_valid fall while loading
//   detect_add           out state is DECODE_ADDRESS
//   lfd_state            out state is LOAD_FIRST_DATA
//   ld_state             out state is LOAD_DATA
//   laf_state            out state is LOAD_AFTER_FULL
//   full_state           out state is FIFO_FULL_STATE
//   rst_int_reg          out state is CHECK_PARITY_ERROR
//   write_enb_reg        out FIFO write enable qualifier
//   busy                 out source must hold its current byte
// -----------------------------------------------------------------------------
module router_fsm
  import router_fsm_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              packet_valid,
  input  logic [ADDR_W-1:0] datain,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy
);

  // One slot per encodable address; slots without a physical port read as
  // "not empty" and "no soft reset" so an unused address can never be selected.
  localparam int              SLOTS   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PORTS_W = NUM_PORTS[ADDR_W:0];

  logic [2:0]       port_empty;
  logic [2:0]       port_srst;
  logic [SLOTS-1:0] empty_vec;
  logic [SLOTS-1:0] srst_vec;

  assign port_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign port_srst  = {soft_reset_2, soft_reset_1, soft_reset_0};

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < NUM_PORTS && gi < 3) begin : g_port
        assign empty_vec[gi] = port_empty[gi];
        assign srst_vec[gi]  = port_srst[gi];
      end else begin : g_none
        assign empty_vec[gi] = 1'b0;
        assign srst_vec[gi]  = 1'b0;
      end
    end
  endgenerate

  state_e            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              addr_ok;

  // Addresses at or above the port count (2'b11 for three ports) are ignored.
  assign addr_ok = ({1'b0, datain} < PORTS_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= DA;
      addr_reg  <= '0;
    end else begin
      if (state_reg == DA && packet_valid && addr_ok)
        addr_reg <= datain;

      // Soft reset of the selected port overrides every other transition.
      if (state_reg != DA && srst_vec[addr_reg]) begin
        state_reg <= DA;
      end else begin
        case (state_reg)
          DA: begin
            if (packet_valid && addr_ok)
              state_reg <= empty_vec[datain] ? LFD : WTE;
          end
          LFD: state_reg <= LD;
          LD: begin
            // Full wins over the end of the packet so no byte is lost.
            if (fifo_full)          state_reg <= FFS;
            else if (!packet_valid) state_reg <= LP;
          end
          FFS: begin
            if (!fifo_full) state_reg <= LAF;
          end
          LAF: begin
            if (parity_done)           state_reg <= DA;
            else if (low_packet_valid) state_reg <= LP;
            else                       state_reg <= LD;
          end
          LP:  state_reg <= CPE;
          CPE: state_reg <= fifo_full ? FFS : DA;
          WTE: begin
            // Waits on the latched port, not on whatever datain now shows.
            if (empty_vec[addr_reg]) state_reg <= LFD;
          end
          default: state_reg <= DA;
        endcase
      end
    end
  end

  // Moore decodes of the state register.
  assign detect_add    = (state_reg == DA);
  assign lfd_state     = (state_reg == LFD);
  assign ld_state      = (state_reg == LD);
  assign laf_state     = (state_reg == LAF);
  assign full_state    = (state_reg == FFS);
  assign rst_int_reg   = (state_reg == CPE);
  assign write_enb_reg = (state_reg == LFD) || (state_reg == LD) ||
                         (state_reg == LAF) || (state_reg == LP);
  assign busy          = !((state_reg == DA) || (state_reg == LD));

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       packet_valid;
  logic [1:0] datain;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_packet_valid;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg, busy;

  router_fsm dut (
    .clk              (clk),
    .resetn           (resetn),
    .packet_valid     (packet_valid),
    .datain           (datain),
    .fifo_full        (fifo_full),
    .fifo_empty_0     (fifo_empty_0),
    .fifo_empty_1     (fifo_empty_1),
    .fifo_empty_2     (fifo_empty_2),
    .soft_reset_0     (soft_reset_0),
    .soft_reset_1     (soft_reset_1),
    .soft_reset_2     (soft_reset_2),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .write_enb_reg    (write_enb_reg),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Observed output vector: {detect_add,lfd,ld,laf,full,rst_int,wen,busy}
  logic [7:0] outs;
  assign outs = {detect_add, lfd_state, ld_state, laf_state,
                 full_state, rst_int_reg, write_enb_reg, busy};

  localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3,
                 S_LAF = 4, S_LP = 5, S_CPE = 6, S_WTE = 7;

  // Expected output vector for each state, written out from the decode table.
  function automatic logic [7:0] exp_of(input int s);
    case (s)
      S_DA:    return 8'b1000_0000;
      S_LFD:   return 8'b0100_0011;
      S_LD:    return 8'b0010_0010;
      S_FFS:   return 8'b0000_1001;
      S_LAF:   return 8'b0001_0011;
      S_LP:    return 8'b0000_0011;
      S_CPE:   return 8'b0000_0101;
      default: return 8'b0000_0001;  // WTE
    endcase
  endfunction

  logic [7:0] sb[$];
  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Push the expected outputs for the state after the next edge, clock, then
  // pop and compare one step after the edge.
  task automatic tick(input string tag, input int s);
    logic [7:0] e;
    sb.push_back(exp_of(s));
    @(posedge clk);
    #1;
    if (write_enb_reg) wen_cnt++;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, outs, 8'hxx);
    end else begin
      e = sb.pop_front();
      check_eq(tag, outs, e);
    end
  endtask

  initial begin
    resetn = 1'b0; packet_valid = 1'b0; datain = 2'b00; fifo_full = 1'b0;
    fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset", outs, exp_of(S_DA));
    resetn = 1'b1;
    tick("idle", S_DA);

    // Normal packet to port 1: DA,LFD,LD x4,LP,CPE,DA
    packet_valid = 1'b1; datain = 2'b01; fifo_empty_1 = 1'b1; wen_cnt = 0;
    tick("p1_lfd", S_LFD);
    datain = 2'b00;
    tick("p1_ld0", S_LD);
    tick("p1_ld1", S_LD);
    tick("p1_ld2", S_LD);
    tick("p1_ld3", S_LD);
    packet_valid = 1'b0;
    tick("p1_lp", S_LP);
    tick("p1_cpe", S_CPE);
    tick("p1_da", S_DA);
    check_eq("p1_wen_cycles", 8'(wen_cnt), 8'd6);
    fifo_empty_1 = 1'b0;

    // Invalid address 2'b11 is ignored
    packet_valid = 1'b1; datain = 2'b11;
    tick("inv_0", S_DA);
    tick("inv_1", S_DA);
    tick("inv_2", S_DA);
    packet_valid = 1'b0;
    tick("inv_idle", S_DA);

    // Port 2 busy: WTE for 5 cycles; datain/port 0 changes must not release it
    packet_valid = 1'b1; datain = 2'b10; fifo_empty_2 = 1'b0;
    tick("wte_0", S_WTE);
    datain = 2'b00; fifo_empty_0 = 1'b1;
    tick("wte_1", S_WTE);
    tick("wte_2", S_WTE);
    tick("wte_3", S_WTE);
    tick("wte_4", S_WTE);
    fifo_empty_0 = 1'b0; fifo_empty_2 = 1'b1;
    tick("wte_lfd", S_LFD);
    tick("wte_ld", S_LD);

    // Full in LD: FFS x3, then LAF -> LP (low_packet_valid) -> CPE -> DA
    fifo_full = 1'b1;
    tick("ffs_0", S_FFS);
    tick("ffs_1", S_FFS);
    tick("ffs_2", S_FFS);
    fifo_full = 1'b0; low_packet_valid = 1'b1; packet_valid = 1'b0;
    tick("ffs_laf", S_LAF);
    tick("laf_lp", S_LP);
    low_packet_valid = 1'b0;
    tick("laf_cpe", S_CPE);
    tick("laf_da", S_DA);
    fifo_empty_2 = 1'b0;

    // fifo_full with packet_valid low in LD -> FFS; soft resets
    packet_valid = 1'b1; datain = 2'b00; fifo_empty_0 = 1'b1;
    tick("b_lfd", S_LFD);
    tick("b_ld", S_LD);
    packet_valid = 1'b0; fifo_full = 1'b1;
    tick("b_full_prio", S_FFS);
    soft_reset_1 = 1'b1;
    tick("srst_other", S_FFS);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    tick("srst_sel", S_DA);
    soft_reset_0 = 1'b0; fifo_full = 1'b0;

    // parity_done and low_packet_valid together in LAF -> DA
    packet_valid = 1'b1; datain = 2'b00;
    tick("c_lfd", S_LFD);
    tick("c_ld", S_LD);
    fifo_full = 1'b1;
    tick("c_ffs", S_FFS);
    fifo_full = 1'b0; parity_done = 1'b1; low_packet_valid = 1'b1;
    tick("c_laf", S_LAF);
    tick("c_pd_prio", S_DA);
    parity_done = 1'b0; low_packet_valid = 1'b0;

    // LAF -> LD, and CPE -> FFS when the FIFO is full
    tick("d_lfd", S_LFD);
    tick("d_ld", S_LD);
    fifo_full = 1'b1;
    tick("d_ffs", S_FFS);
    fifo_full = 1'b0;
    tick("d_laf", S_LAF);
    tick("d_laf_ld", S_LD);
    packet_valid = 1'b0;
    tick("d_lp", S_LP);
    fifo_full = 1'b1;
    tick("d_cpe", S_CPE);
    tick("d_cpe_ffs", S_FFS);
    fifo_full = 1'b0;
    tick("d_laf2", S_LAF);
    parity_done = 1'b1;
    tick("d_da", S_DA);
    parity_done = 1'b0;

    // Soft reset of the latched port while waiting in WTE
    packet_valid = 1'b1; datain = 2'b10; fifo_empty_2 = 1'b0;
    tick("e_wte", S_WTE);
    packet_valid = 1'b0; soft_reset_2 = 1'b1;
    tick("e_srst_wte", S_DA);
    soft_reset_2 = 1'b0;

    // Asynchronous reset in the middle of LD
    packet_valid = 1'b1; datain = 2'b00;
    tick("f_lfd", S_LFD);
    tick("f_ld", S_LD);
    #2 resetn = 1'b0;
    #1 check_eq("async_rst", outs, exp_of(S_DA));
    @(posedge clk);
    #1 check_eq("async_rst_hold", outs, exp_of(S_DA));
    resetn = 1'b1; packet_valid = 1'b0;
    tick("f_idle", S_DA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
